// File: rtl/arb_nmks_rr.sv
// arb_nmks_rr: NUM_M x NUM_S bus arbiter with per-slave grant lock and read-ID FIFOs for response routing.
// Latency: 0 cycles on both the request path (master->slave) and the response path (slave->master).
// Backpressure: s_ack is reflected onto the granted m_ack; a slave is not offered while its ID FIFO is full.
// Config macro ARB_NMKS_RR_RR_EN: defined -> round-robin per slave, undefined -> fixed priority (lowest index wins).
module arb_nmks_rr #(
  parameter int NUM_M      = 2,
  parameter int NUM_S      = 4,
  parameter int SEL_LSB    = 28,
  parameter int RESP_DEPTH = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NUM_M-1:0]    m_req,
  input  logic [NUM_M-1:0]    m_we,
  input  logic [NUM_M*32-1:0] m_addr,
  input  logic [NUM_M*4-1:0]  m_be,
  input  logic [NUM_M*32-1:0] m_wdata,
  output logic [NUM_M-1:0]    m_ack,
  output logic [NUM_M-1:0]    m_resp,
  output logic [NUM_M*32-1:0] m_rdata,
  output logic [NUM_S-1:0]    s_req,
  output logic [NUM_S-1:0]    s_we,
  output logic [NUM_S*32-1:0] s_addr,
  output logic [NUM_S*4-1:0]  s_be,
  output logic [NUM_S*32-1:0] s_wdata,
  input  logic [NUM_S-1:0]    s_ack,
  input  logic [NUM_S-1:0]    s_resp,
  input  logic [NUM_S*32-1:0] s_rdata
);

  localparam int SEL_W = $clog2(NUM_S);
  localparam int MW    = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam int PW    = $clog2(RESP_DEPTH);
  localparam int CW    = $clog2(RESP_DEPTH) + 1;

  // Per-master read accounting
  logic [CW-1:0]    r_out_cnt [NUM_M];
  logic [SEL_W-1:0] r_out_tgt [NUM_M];
  // Per-slave ID FIFO, grant lock and (optionally) round-robin pointer
  logic [MW-1:0]    r_fifo    [NUM_S][RESP_DEPTH];
  logic [PW-1:0]    r_wptr    [NUM_S];
  logic [PW-1:0]    r_rptr    [NUM_S];
  logic [CW-1:0]    r_fcnt    [NUM_S];
  logic [NUM_S-1:0] r_lock_vld;
  logic [MW-1:0]    r_lock_idx [NUM_S];
`ifdef ARB_NMKS_RR_RR_EN
  logic [MW-1:0]    r_ptr     [NUM_S];
`endif

  logic [SEL_W-1:0] w_sel     [NUM_M];
  logic [SEL_W-1:0] w_tgt     [NUM_M];
  logic [NUM_M-1:0] w_elig    [NUM_S];
  logic [MW-1:0]    w_gnt     [NUM_S];
  logic [MW-1:0]    w_head    [NUM_S];
  logic [NUM_S-1:0] w_full, w_sreq, w_hs, w_push, w_pop;
  logic [NUM_M-1:0] w_inc, w_dec;
  logic [SEL_W-1:0] w_inc_tgt [NUM_M];

  // Decode each master's target slave; out-of-range selects fold onto the last slave
  always_comb begin
    for (int m = 0; m < NUM_M; m++) begin
      w_sel[m] = m_addr[m*32 + SEL_LSB +: SEL_W];
      if (int'(w_sel[m]) >= NUM_S) w_tgt[m] = SEL_W'(NUM_S - 1);
      else                         w_tgt[m] = w_sel[m];
    end
  end

  // A master may only be offered to the slave its existing reads went to, and only below the read limit
  always_comb begin
    for (int s = 0; s < NUM_S; s++) begin
      for (int m = 0; m < NUM_M; m++) begin
        w_elig[s][m] = m_req[m] && (w_tgt[m] == SEL_W'(s)) &&
                       (r_out_cnt[m] < CW'(RESP_DEPTH)) &&
                       ((r_out_cnt[m] == '0) || (r_out_tgt[m] == SEL_W'(s)));
      end
    end
  end

  // Pick a master per slave: a pending locked grant wins, otherwise arbitrate
  always_comb begin : p_gnt
    logic found;
    int   idx;
    found = 1'b0;
    idx   = 0;
    for (int s = 0; s < NUM_S; s++) begin
      w_gnt[s] = '0;
      found    = 1'b0;
      if (r_lock_vld[s] && w_elig[s][r_lock_idx[s]]) begin
        w_gnt[s] = r_lock_idx[s];
      end else begin
`ifdef ARB_NMKS_RR_RR_EN
        for (int k = 0; k < NUM_M; k++) begin
          idx = (int'(r_ptr[s]) + k) % NUM_M;
          if (!found && w_elig[s][idx]) begin
            w_gnt[s] = MW'(idx);
            found    = 1'b1;
          end
        end
`else
        for (int k = NUM_M - 1; k >= 0; k--) begin
          if (w_elig[s][k]) w_gnt[s] = MW'(k);
        end
`endif
      end
    end
  end

  // Per-slave handshake, FIFO push/pop and the master at the FIFO head
  always_comb begin
    for (int s = 0; s < NUM_S; s++) begin
      w_full[s] = (r_fcnt[s] == CW'(RESP_DEPTH));
      w_sreq[s] = rst_ni && (|w_elig[s]) && !w_full[s];
      w_hs[s]   = w_sreq[s] && s_ack[s];
      w_push[s] = w_hs[s] && !m_we[w_gnt[s]];
      w_pop[s]  = rst_ni && s_resp[s] && (r_fcnt[s] != '0);
      w_head[s] = r_fifo[s][r_rptr[s]];
    end
  end

  // Route granted requests to slaves and popped responses back to their masters
  always_comb begin
    m_ack   = '0;
    m_resp  = '0;
    m_rdata = '0;
    s_req   = '0;
    s_we    = '0;
    s_addr  = '0;
    s_be    = '0;
    s_wdata = '0;
    for (int s = 0; s < NUM_S; s++) begin
      if (w_sreq[s]) begin
        s_req[s]            = 1'b1;
        s_we[s]             = m_we[w_gnt[s]];
        s_addr[s*32 +: 32]  = m_addr[int'(w_gnt[s])*32 +: 32];
        s_be[s*4 +: 4]      = m_be[int'(w_gnt[s])*4 +: 4];
        s_wdata[s*32 +: 32] = m_wdata[int'(w_gnt[s])*32 +: 32];
        m_ack[w_gnt[s]]     = s_ack[s];
      end
      if (w_pop[s]) begin
        m_resp[w_head[s]]                    = 1'b1;
        m_rdata[int'(w_head[s])*32 +: 32]    = s_rdata[s*32 +: 32];
      end
    end
  end

  // Collect per-master read issue/retire events across all slaves
  always_comb begin
    for (int m = 0; m < NUM_M; m++) begin
      w_inc[m]     = 1'b0;
      w_dec[m]     = 1'b0;
      w_inc_tgt[m] = '0;
      for (int s = 0; s < NUM_S; s++) begin
        if (w_push[s] && (w_gnt[s] == MW'(m))) begin
          w_inc[m]     = 1'b1;
          w_inc_tgt[m] = SEL_W'(s);
        end
        if (w_pop[s] && (w_head[s] == MW'(m))) w_dec[m] = 1'b1;
      end
    end
  end

  // Outstanding-read count per master and the slave those reads target
  always_ff @(posedge clk_i) begin
    for (int m = 0; m < NUM_M; m++) begin
      if (!rst_ni) begin
        r_out_cnt[m] <= '0;
        r_out_tgt[m] <= '0;
      end else begin
        if (w_inc[m] && !w_dec[m])      r_out_cnt[m] <= r_out_cnt[m] + CW'(1);
        else if (!w_inc[m] && w_dec[m]) r_out_cnt[m] <= r_out_cnt[m] - CW'(1);
        if (w_inc[m]) r_out_tgt[m] <= w_inc_tgt[m];
      end
    end
  end

  // ID FIFO storage; occupancy lives in the pointers, so contents need no reset
  always_ff @(posedge clk_i) begin
    for (int s = 0; s < NUM_S; s++) begin
      if (w_push[s]) r_fifo[s][r_wptr[s]] <= w_gnt[s];
    end
  end

  // FIFO pointers, grant lock while a request is stalled, round-robin pointer on handshake
  always_ff @(posedge clk_i) begin
    for (int s = 0; s < NUM_S; s++) begin
      if (!rst_ni) begin
        r_wptr[s]     <= '0;
        r_rptr[s]     <= '0;
        r_fcnt[s]     <= '0;
        r_lock_vld[s] <= 1'b0;
        r_lock_idx[s] <= '0;
`ifdef ARB_NMKS_RR_RR_EN
        r_ptr[s]      <= '0;
`endif
      end else begin
        if (w_push[s]) r_wptr[s] <= r_wptr[s] + PW'(1);
        if (w_pop[s])  r_rptr[s] <= r_rptr[s] + PW'(1);
        if (w_push[s] && !w_pop[s])      r_fcnt[s] <= r_fcnt[s] + CW'(1);
        else if (!w_push[s] && w_pop[s]) r_fcnt[s] <= r_fcnt[s] - CW'(1);
        r_lock_vld[s] <= w_sreq[s] && !s_ack[s];
        if (w_sreq[s] && !s_ack[s]) r_lock_idx[s] <= w_gnt[s];
`ifdef ARB_NMKS_RR_RR_EN
        if (w_hs[s]) r_ptr[s] <= (int'(w_gnt[s]) == NUM_M - 1) ? '0 : w_gnt[s] + MW'(1);
`endif
      end
    end
  end

endmodule

// File: tb/tb_arb_nmks_rr.sv
// tb_arb_nmks_rr: directed stimulus with a queue-based reference model compared every cycle,
// plus literal expectations for the arbitration, stall, depth-limit, target-switch and reset cases.
module tb_arb_nmks_rr;
  localparam int NM      = 2;
  localparam int NS      = 4;
  localparam int D       = 4;
  localparam int SEL_LSB = 28;
  localparam int SEL_W   = 2;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic [NM-1:0]     m_req, m_we, m_ack, m_resp;
  logic [NM*32-1:0]  m_addr, m_wdata, m_rdata;
  logic [NM*4-1:0]   m_be;
  logic [NS-1:0]     s_req, s_we, s_ack, s_resp;
  logic [NS*32-1:0]  s_addr, s_wdata, s_rdata;
  logic [NS*4-1:0]   s_be;

  always #5 clk_i = ~clk_i;

  arb_nmks_rr #(.NUM_M(NM), .NUM_S(NS), .SEL_LSB(SEL_LSB), .RESP_DEPTH(D)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_be(m_be), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_resp(m_resp), .m_rdata(m_rdata),
    .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_be(s_be), .s_wdata(s_wdata),
    .s_ack(s_ack), .s_resp(s_resp), .s_rdata(s_rdata)
  );

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Reference model state: per-slave queue of master ids awaiting a response
  int q [NS][$];
  int mcnt [NM];
  int mtgt [NM];
  bit lock_v [NS];
  int lock_i [NS];
  int ptr [NS];
  bit e_sreq [NS];
  int e_gnt [NS];

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  function automatic int tgt_of(int m);
    logic [31:0] a;
    int f;
    a = m_addr[m*32 +: 32];
    f = int'(a[SEL_LSB +: SEL_W]);
    return (f >= NS) ? NS - 1 : f;
  endfunction

  function automatic bit elig(int m, int s);
    return m_req[m] && (tgt_of(m) == s) && (mcnt[m] < D) && (mcnt[m] == 0 || mtgt[m] == s);
  endfunction

  function automatic int pick(int s);
    if (lock_v[s] && elig(lock_i[s], s)) return lock_i[s];
`ifdef ARB_NMKS_RR_RR_EN
    for (int k = 0; k < NM; k++) begin
      int m;
      m = (ptr[s] + k) % NM;
      if (elig(m, s)) return m;
    end
`else
    for (int m = 0; m < NM; m++) if (elig(m, s)) return m;
`endif
    return -1;
  endfunction

  // Every cycle: compute expected outputs from the model and compare against the DUT
  always @(negedge clk_i) begin
    logic [NM-1:0]    x_mack, x_mresp;
    logic [NM*32-1:0] x_mrdata;
    logic [NS-1:0]    x_sreq, x_swe;
    logic [NS*32-1:0] x_saddr, x_swdata;
    logic [NS*4-1:0]  x_sbe;
    int g;
    x_mack = '0; x_mresp = '0; x_mrdata = '0;
    x_sreq = '0; x_swe = '0; x_saddr = '0; x_swdata = '0; x_sbe = '0;
    for (int s = 0; s < NS; s++) begin
      e_sreq[s] = 1'b0;
      e_gnt[s]  = -1;
      if (rst_ni === 1'b1) begin
        g = pick(s);
        if (g >= 0 && q[s].size() < D) begin
          e_sreq[s] = 1'b1;
          e_gnt[s]  = g;
          x_sreq[s] = 1'b1;
          x_swe[s]  = m_we[g];
          x_saddr[s*32 +: 32]  = m_addr[g*32 +: 32];
          x_swdata[s*32 +: 32] = m_wdata[g*32 +: 32];
          x_sbe[s*4 +: 4]      = m_be[g*4 +: 4];
          if (s_ack[s]) x_mack[g] = 1'b1;
        end
        if (s_resp[s] && q[s].size() > 0) begin
          x_mresp[q[s][0]] = 1'b1;
          x_mrdata[q[s][0]*32 +: 32] = s_rdata[s*32 +: 32];
        end
      end
    end
    if (chk_en) begin
      check("model_m_ack",   m_ack,   x_mack);
      check("model_m_resp",  m_resp,  x_mresp);
      check("model_m_rdata", m_rdata, x_mrdata);
      check("model_s_req",   s_req,   x_sreq);
      check("model_s_we",    s_we,    x_swe);
      check("model_s_addr",  s_addr,  x_saddr);
      check("model_s_wdata", s_wdata, x_swdata);
      check("model_s_be",    s_be,    x_sbe);
    end
  end

  // Advance the model on each clock edge
  always @(posedge clk_i) begin
    int dlt [NM];
    int h;
    for (int m = 0; m < NM; m++) dlt[m] = 0;
    if (!rst_ni) begin
      for (int s = 0; s < NS; s++) begin
        q[s].delete();
        lock_v[s] <= 1'b0;
        lock_i[s] <= 0;
        ptr[s]    <= 0;
      end
      for (int m = 0; m < NM; m++) begin
        mcnt[m] <= 0;
        mtgt[m] <= 0;
      end
    end else begin
      for (int s = 0; s < NS; s++) begin
        if (s_resp[s] && q[s].size() > 0) begin
          h = q[s].pop_front();
          dlt[h] = dlt[h] - 1;
        end
        if (e_sreq[s] && s_ack[s]) begin
          ptr[s]    <= (e_gnt[s] + 1) % NM;
          lock_v[s] <= 1'b0;
          if (!m_we[e_gnt[s]]) begin
            q[s].push_back(e_gnt[s]);
            dlt[e_gnt[s]] = dlt[e_gnt[s]] + 1;
            mtgt[e_gnt[s]] <= s;
          end
        end else if (e_sreq[s]) begin
          lock_v[s] <= 1'b1;
          lock_i[s] <= e_gnt[s];
        end else begin
          lock_v[s] <= 1'b0;
        end
      end
      for (int m = 0; m < NM; m++) mcnt[m] <= mcnt[m] + dlt[m];
    end
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    m_req = '0; m_we = '0; m_addr = '0; m_be = '0; m_wdata = '0;
    s_ack = '0; s_resp = '0; s_rdata = '0;
  endtask

  task automatic set_m(input int m, input bit we, input logic [31:0] a);
    m_req[m] = 1'b1;
    m_we[m]  = we;
    m_addr[m*32 +: 32]  = a;
    m_be[m*4 +: 4]      = 4'hF;
    m_wdata[m*32 +: 32] = a ^ 32'h5A5A_0000;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    idle();
    cyc();
    chk_en = 1'b1;
    cyc();
    rst_ni = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] exp_ack;
    rst_ni = 1'b0;
    idle();
    do_reset();

    // Reset state: nothing requested, nothing offered
    @(negedge clk_i);
    check("reset_s_req", s_req, 4'b0000);
    check("reset_m_ack", m_ack, 2'b00);
    cyc();

    // Two masters writing to slave 1 every cycle with s_ack high
    do_reset();
    set_m(0, 1'b1, 32'h1000_0000);
    set_m(1, 1'b1, 32'h1000_0010);
    s_ack[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
`ifdef ARB_NMKS_RR_RR_EN
      exp_ack = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
      exp_ack = 2'b01;
`endif
      check("arb_seq_m_ack", m_ack, exp_ack);
      cyc();
    end

    // Slave 1 stalls for 3 cycles: grant and address stay on M0, then M1 is served
    do_reset();
    set_m(0, 1'b0, 32'h1000_0000);
    set_m(1, 1'b1, 32'h1000_0100);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check("stall_s_req", s_req[1], 1'b1);
      check("stall_s_addr", s_addr[32 +: 32], 32'h1000_0000);
      check("stall_m_ack", m_ack, 2'b00);
      cyc();
    end
    s_ack[1] = 1'b1;
    @(negedge clk_i);
    check("stall_hs_m0", m_ack, 2'b01);
    cyc();
    m_req[0] = 1'b0;
    @(negedge clk_i);
    check("stall_hs_m1", m_ack, 2'b10);
    check("stall_m1_addr", s_addr[32 +: 32], 32'h1000_0100);
    cyc();

    // Depth limit: four reads accepted, fifth held until a response returns
    do_reset();
    set_m(0, 1'b0, 32'h2000_0000);
    s_ack[2] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      check("depth_accept", m_ack, 2'b01);
      cyc();
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      check("depth_block_ack", m_ack, 2'b00);
      check("depth_block_sreq", s_req[2], 1'b0);
      cyc();
    end
    s_resp[2] = 1'b1;
    s_rdata[64 +: 32] = 32'hAAAA_0001;
    @(negedge clk_i);
    check("depth_resp", m_resp, 2'b01);
    check("depth_rdata", m_rdata, 64'h0000_0000_AAAA_0001);
    check("depth_resp_ack", m_ack, 2'b00);
    cyc();
    s_resp = '0;
    @(negedge clk_i);
    check("depth_reopen_ack", m_ack, 2'b01);
    check("depth_rdata_idle", m_rdata, 64'h0);
    cyc();

    // Target switch: read to slave 0 outstanding blocks a request to slave 3
    do_reset();
    set_m(0, 1'b0, 32'h0000_0000);
    s_ack[0] = 1'b1;
    @(negedge clk_i);
    check("switch_first_ack", m_ack, 2'b01);
    cyc();
    s_ack[0] = 1'b0;
    set_m(0, 1'b0, 32'h3000_0000);
    s_ack[3] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      check("switch_hold_ack", m_ack, 2'b00);
      check("switch_hold_sreq", s_req[3], 1'b0);
      cyc();
    end
    s_resp[0] = 1'b1;
    s_rdata[0 +: 32] = 32'h1234_5678;
    @(negedge clk_i);
    check("switch_resp", m_resp, 2'b01);
    check("switch_rdata", m_rdata[31:0], 32'h1234_5678);
    cyc();
    s_resp = '0;
    @(negedge clk_i);
    check("switch_grant_ack", m_ack, 2'b01);
    check("switch_grant_addr", s_addr[96 +: 32], 32'h3000_0000);
    cyc();

    // Response ordering across masters on one slave
    do_reset();
    set_m(0, 1'b0, 32'h2000_0000);
    set_m(1, 1'b0, 32'h2000_0004);
    s_ack[2] = 1'b1;
    @(negedge clk_i);
    check("order_ack0", m_ack, 2'b01);
    cyc();
    m_req[0] = 1'b0;
    @(negedge clk_i);
    check("order_ack1", m_ack, 2'b10);
    cyc();
    m_req = '0;
    s_ack = '0;
    s_resp[2] = 1'b1;
    s_rdata[64 +: 32] = 32'h0000_0011;
    @(negedge clk_i);
    check("order_resp0", m_resp, 2'b01);
    check("order_rdata0", m_rdata, 64'h0000_0000_0000_0011);
    cyc();
    s_rdata[64 +: 32] = 32'h0000_0022;
    @(negedge clk_i);
    check("order_resp1", m_resp, 2'b10);
    check("order_rdata1", m_rdata, 64'h0000_0022_0000_0000);
    cyc();
    s_resp = '0;

    // Reset with two reads outstanding discards them
    do_reset();
    set_m(0, 1'b0, 32'h1000_0000);
    s_ack[1] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      check("rst_pre_ack", m_ack, 2'b01);
      cyc();
    end
    rst_ni = 1'b0;
    s_resp[1] = 1'b1;
    s_rdata[32 +: 32] = 32'hDEAD_BEEF;
    @(negedge clk_i);
    check("rst_s_req", s_req, 4'b0000);
    check("rst_m_ack", m_ack, 2'b00);
    check("rst_m_resp", m_resp, 2'b00);
    cyc();
    rst_ni = 1'b1;
    m_req = '0;
    s_ack = '0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      check("rst_drop_resp", m_resp, 2'b00);
      check("rst_drop_rdata", m_rdata, 64'h0);
      cyc();
    end
    s_resp = '0;
    set_m(0, 1'b0, 32'h2000_0000);
    s_ack[2] = 1'b1;
    @(negedge clk_i);
    check("rst_cnt_cleared", m_ack, 2'b01);
    cyc();
    idle();
    cyc();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/arb_nmks_rr.md
ARB_NMKS_RR -- requirements
Module: arb_nmks_rr

Interface
REQ-001 SHALL have parameter NUM_M, default 2, meaning number of master ports (1..8).
REQ-002 SHALL have parameter NUM_S, default 4, meaning number of slave ports (2..8).
REQ-003 SHALL have parameter SEL_LSB, default 28, meaning lowest address bit of the slave-select field; field width SEL_W = $clog2(NUM_S).
REQ-004 SHALL have parameter RESP_DEPTH, default 4, meaning outstanding reads per slave and per master (power of two, 2..16).
REQ-005 SHALL have port clk_i  in  1  clock; all state updates on rising edge.
REQ-006 SHALL have port rst_ni  in  1  reset, synchronous, active-low.
REQ-007 SHALL have master-side ports m_req/m_we/m_ack/m_resp  in/in/out/out  NUM_M  per-master request, write-enable, accept, read response.
REQ-008 SHALL have master-side ports m_addr/m_be/m_wdata  in  NUM_M*32/NUM_M*4/NUM_M*32, and m_rdata  out  NUM_M*32; master i occupies slice [i*W +: W].
REQ-009 SHALL have slave-side ports s_req/s_we  out  NUM_S, s_addr/s_wdata  out  NUM_S*32, s_be  out  NUM_S*4, s_ack/s_resp  in  NUM_S, s_rdata  in  NUM_S*32, sliced the same way.

Function
REQ-010 SHALL decode target slave of master m as m_addr[m][SEL_LSB +: SEL_W]; indices >= NUM_S SHALL map to slave NUM_S-1.
REQ-011 SHALL transfer a request when s_req[s] && s_ack[s]; m_ack[m] SHALL equal s_ack[s] for the granted master only, 0 otherwise (0-cycle combinational path).
REQ-012 SHALL treat master m as eligible for slave s when m_req[m], target==s, out_cnt[m]<RESP_DEPTH, and out_cnt[m]==0 or out_tgt[m]==s.
REQ-013 SHALL drive s_req[s]=0 and all s_* fields of slave s to 0 when it has no eligible master or its ID FIFO is full.
REQ-014 SHALL lock the grant of slave s in a register while s_req[s] && !s_ack[s]; grant SHALL change only after the handshake or when the locked master drops m_req.
REQ-015 SHALL, per slave, keep an ID FIFO of depth RESP_DEPTH, pushing the granted master index on each accepted read (we=0); writes SHALL NOT push.
REQ-016 SHALL route s_resp[s]/s_rdata[s] to the master at FIFO head and pop it in the same cycle (0-cycle response path); s_resp with empty FIFO SHALL be dropped.
REQ-017 SHALL keep per-master out_cnt (width $clog2(RESP_DEPTH)+1) and out_tgt: +1 on accepted read, -1 on delivered response, unchanged when both occur in one cycle; out_tgt loads on accept.
REQ-018 SHALL block a push when the FIFO is full even if a pop occurs that cycle.
REQ-019 SHALL drive m_rdata[m]=0 whenever m_resp[m]=0.
REQ-020 SHALL deliver responses to each master in issue order; a master never has reads outstanding to two slaves.

Reset
REQ-021 SHALL, while rst_ni=0 at a clock edge, clear all FIFOs, out_cnt, out_tgt, grant locks and round-robin pointers (pointer=0).
REQ-022 SHALL force all m_ack, m_resp, s_req to 0 during reset; reset mid-transaction SHALL discard outstanding reads and later s_resp SHALL be dropped.

Configuration
REQ-023 SHALL use macro ARB_NMKS_RR_RR_EN to select arbitration policy.
REQ-024 SHALL, with ARB_NMKS_RR_RR_EN defined, grant round-robin per slave starting at (last handshaken master + 1) mod NUM_M, pointer updated only on handshake.
REQ-025 SHALL, without ARB_NMKS_RR_RR_EN, grant fixed priority, lowest master index first, with no pointer state.

Verification
REQ-026 SHALL cover: M0 and M1 request slave 1 every cycle, s_ack=1 (RR_EN) -> grants alternate M0,M1,M0,M1; without RR_EN -> M0 every cycle.
REQ-027 SHALL cover: M0 read 0x1000_0000, slave 1 holds s_ack=0 for 3 cycles while M1 also requests -> grant stays M0, s_addr constant, M1 served after handshake.
REQ-028 SHALL cover: M0 issues 4 reads to slave 2 (RESP_DEPTH=4), no responses -> 5th read not offered (m_ack=0) until one s_resp returns.
REQ-029 SHALL cover: M0 read outstanding to slave 0, M0 then requests slave 3 -> stalled until response 0x1234_5678 delivered on m_rdata[0], then slave 3 granted.
REQ-030 SHALL cover: rst_ni=0 for 1 cycle with 2 reads outstanding -> subsequent s_resp dropped, all m_resp=0, out_cnt=0.
